// File: rtl/snn_pkg.sv
// Shared SNN definitions: ID width helper, event payload layout and drop counter width.
package snn_pkg;

  function automatic int unsigned id_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned DROP_W        = 8;
  localparam int unsigned N_NEURONS_DEF = 4;
  localparam int unsigned TS_W_DEF      = 8;
  localparam int unsigned ID_W_DEF      = id_w(N_NEURONS_DEF);
  localparam int unsigned EV_W          = ID_W_DEF + TS_W_DEF;

  // Event word as seen on ev_data: neuron id in the MSBs, timestamp below.
  typedef struct packed {
    logic [ID_W_DEF-1:0] id;
    logic [TS_W_DEF-1:0] ts;
  } spike_ev_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; pointers carry a wrap bit so full and empty are distinguishable.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  output logic                     full,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign level   = wptr - rptr;
  assign dout    = mem[rptr[AW-1:0]];
  assign do_pop  = pop & ~empty;
  // A pop frees the slot the same edge, so a full FIFO still accepts.
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wptr[AW-1:0]] <= din;
        wptr              <= wptr + (AW+1)'(1);
      end
      if (do_pop) rptr <= rptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/spike_event_tx.sv
// Address-event transmitter: timestamps spikes, serialises them lowest-index-first
// into a FIFO and counts events lost to a still-pending neuron.
module spike_event_tx
  import snn_pkg::*;
#(
  parameter int unsigned N_NEURONS = 4,
  parameter int unsigned TS_W      = 8,
  parameter int unsigned DEPTH     = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [N_NEURONS-1:0]               spikes,
  output logic                               ev_valid,
  input  logic                               ev_ready,
  output logic [id_w(N_NEURONS)+TS_W-1:0]    ev_data,
  output logic [$clog2(DEPTH):0]             fifo_level,
  output logic [DROP_W-1:0]                  drop_count
);

  localparam int unsigned ID_W  = id_w(N_NEURONS);
  localparam int unsigned CNT_W = $clog2(N_NEURONS + 1);

  logic [TS_W-1:0]      tnow;
  logic [N_NEURONS-1:0] pend;
  logic [TS_W-1:0]      ts [N_NEURONS];

  logic                 sel_valid;
  logic [ID_W-1:0]      sel_id;
  logic [TS_W-1:0]      sel_ts;
  logic [N_NEURONS-1:0] sel_oh;
  logic [N_NEURONS-1:0] grant;
  logic [N_NEURONS-1:0] drop_vec;
  logic [CNT_W-1:0]     drop_num;
  logic [DROP_W:0]      drop_sum;
  logic [DROP_W-1:0]    drop_next;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 push;
  logic                 pop;

  // Priority arbiter: descending scan so the lowest pending index is kept last.
  always_comb begin
    sel_valid = 1'b0;
    sel_id    = '0;
    sel_ts    = '0;
    sel_oh    = '0;
    for (int i = int'(N_NEURONS) - 1; i >= 0; i--) begin
      if (pend[i]) begin
        sel_valid = 1'b1;
        sel_id    = ID_W'(i);
        sel_ts    = ts[i];
        sel_oh    = '0;
        sel_oh[i] = 1'b1;
      end
    end
  end

  assign ev_valid = ~fifo_empty;
  assign pop      = ev_valid & ev_ready;
  assign push     = sel_valid & (~fifo_full | pop);
  assign grant    = push ? sel_oh : '0;
  // A spike only drops if its neuron is pending and not being drained this edge.
  assign drop_vec = spikes & pend & ~grant;

  always_comb begin
    drop_num = '0;
    for (int i = 0; i < int'(N_NEURONS); i++) drop_num = drop_num + CNT_W'(drop_vec[i]);
    drop_sum  = (DROP_W+1)'(drop_count) + (DROP_W+1)'(drop_num);
    drop_next = drop_sum[DROP_W] ? {DROP_W{1'b1}} : drop_sum[DROP_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tnow       <= '0;
      pend       <= '0;
      drop_count <= '0;
      for (int i = 0; i < int'(N_NEURONS); i++) ts[i] <= '0;
    end else begin
      tnow       <= tnow + TS_W'(1);
      drop_count <= drop_next;
      for (int i = 0; i < int'(N_NEURONS); i++) begin
        if (spikes[i] && !drop_vec[i]) begin
          pend[i] <= 1'b1;
          ts[i]   <= tnow;
        end else if (grant[i]) begin
          pend[i] <= 1'b0;
        end
      end
    end
  end

  sync_fifo #(
    .WIDTH (ID_W + TS_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   ({sel_id, sel_ts}),
    .full  (fifo_full),
    .pop   (pop),
    .dout  (ev_data),
    .empty (fifo_empty),
    .level (fifo_level)
  );

endmodule

// File: tb/tb_spike_event_tx.sv
// Bench for spike_event_tx: queue-based event model checked every cycle plus directed literal checks.
module tb_spike_event_tx;
  import snn_pkg::*;

  localparam int unsigned N   = 4;
  localparam int unsigned TSW = 8;
  localparam int unsigned DEP = 4;
  localparam int unsigned IDW = id_w(N);
  localparam int unsigned EVW = IDW + TSW;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   spikes = '0;
  logic           ev_ready = 1'b0;
  logic           ev_valid;
  logic [EVW-1:0] ev_data;
  logic [$clog2(DEP):0] fifo_level;
  logic [7:0]     drop_count;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  spike_event_tx #(.N_NEURONS(N), .TS_W(TSW), .DEPTH(DEP)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .spikes     (spikes),
    .ev_valid   (ev_valid),
    .ev_ready   (ev_ready),
    .ev_data    (ev_data),
    .fifo_level (fifo_level),
    .drop_count (drop_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [EVW-1:0] mk(input int id, input int t);
    spike_ev_t e;
    e.id = IDW'(id);
    e.ts = TSW'(t);
    return e;
  endfunction

  // Behavioural model: a queue of events, per-neuron pending flag/timestamp, drop tally.
  logic [EVW-1:0] mq[$];
  logic           mpend[N];
  logic [TSW-1:0] mts[N];
  int             mdrop = 0;
  int             mtnow = 0;
  bit             mvalid = 1'b0;
  int             win;
  bit             do_pop, do_push;

  always @(posedge clk) begin
    if (!rst_n) begin
      mq.delete();
      for (int i = 0; i < N; i++) begin mpend[i] = 1'b0; mts[i] = '0; end
      mdrop  = 0;
      mtnow  = 0;
      mvalid = 1'b1;
    end else begin
      do_pop = (mq.size() > 0) && ev_ready;
      win = -1;
      for (int i = 0; i < N; i++) if (mpend[i] && win < 0) win = i;
      do_push = (win >= 0) && ((mq.size() < DEP) || do_pop);
      if (do_pop) void'(mq.pop_front());
      if (do_push) begin
        mq.push_back({IDW'(win), mts[win]});
        mpend[win] = 1'b0;
      end
      for (int i = 0; i < N; i++) begin
        if (spikes[i]) begin
          if (mpend[i]) mdrop = (mdrop >= 255) ? 255 : mdrop + 1;
          else begin mpend[i] = 1'b1; mts[i] = TSW'(mtnow); end
        end
      end
      mtnow = (mtnow + 1) % 256;
    end
  end

  always @(negedge clk) begin
    if (mvalid) begin
      check("ev_valid", 32'(ev_valid), 32'(mq.size() != 0));
      check("fifo_level", 32'(fifo_level), mq.size());
      check("drop_count", 32'(drop_count), mdrop);
      if (mq.size() != 0) check("ev_data", 32'(ev_data), 32'(mq[0]));
    end
  end

  // Log of accepted events as delivered by the DUT.
  logic [EVW-1:0] log_q[$];
  always @(posedge clk) if (rst_n && ev_valid && ev_ready) log_q.push_back(ev_data);

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_tnow(input int v);
    int guard = 0;
    while (mtnow != v && guard < 600) begin tick(1); guard++; end
    if (mtnow != v) begin
      checks++;
      $display("FAIL wait_tnow: got %0d expected %0d", mtnow, v);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(2);
    check("rst_valid", 32'(ev_valid), 0);
    check("rst_level", 32'(fifo_level), 0);
    check("rst_drop", 32'(drop_count), 0);
    check("rst_data", 32'(ev_data), 0);
    rst_n = 1'b1;
    ev_ready = 1'b1;

    // Single spike at tnow=5, latency 2
    wait_tnow(5);
    log_q.delete();
    spikes = 4'b0001; tick(1); spikes = '0;
    check("t1_not_yet", 32'(ev_valid), 0);
    tick(1);
    check("t1_valid", 32'(ev_valid), 1);
    check("t1_data", 32'(ev_data), 32'(mk(0, 5)));
    tick(3);
    check("t1_level", 32'(fifo_level), 0);
    check("t1_count", log_q.size(), 1);
    if (log_q.size() >= 1) check("t1_ev", 32'(log_q[0]), 32'(mk(0, 5)));

    // Simultaneous spikes serialised lowest first
    wait_tnow(20);
    log_q.delete();
    spikes = 4'b1011; tick(1); spikes = '0;
    tick(6);
    check("t2_count", log_q.size(), 3);
    if (log_q.size() >= 3) begin
      check("t2_ev0", 32'(log_q[0]), 32'(mk(0, 20)));
      check("t2_ev1", 32'(log_q[1]), 32'(mk(1, 20)));
      check("t2_ev2", 32'(log_q[2]), 32'(mk(3, 20)));
    end

    // Backpressure: FIFO fills at 4, fifth event waits pending
    ev_ready = 1'b0;
    wait_tnow(40);
    log_q.delete();
    spikes = 4'b0001; tick(1);
    spikes = 4'b0010; tick(1);
    spikes = 4'b0100; tick(1);
    spikes = 4'b1000; tick(1);
    spikes = 4'b0001; tick(1);
    spikes = '0; tick(3);
    check("t3_level_full", 32'(fifo_level), 4);
    ev_ready = 1'b1;
    tick(10);
    check("t3_count", log_q.size(), 5);
    if (log_q.size() >= 5) begin
      check("t3_ev0", 32'(log_q[0]), 32'(mk(0, 40)));
      check("t3_ev1", 32'(log_q[1]), 32'(mk(1, 41)));
      check("t3_ev2", 32'(log_q[2]), 32'(mk(2, 42)));
      check("t3_ev3", 32'(log_q[3]), 32'(mk(3, 43)));
      check("t3_ev4", 32'(log_q[4]), 32'(mk(0, 44)));
    end
    check("t3_drop", 32'(drop_count), 0);

    // Timestamp wrap: spike at counter 0 after passing 255
    wait_tnow(0);
    log_q.delete();
    spikes = 4'b0010; tick(1); spikes = '0;
    tick(5);
    check("t4_wrap_count", log_q.size(), 1);
    if (log_q.size() >= 1) check("t4_wrap_ev", 32'(log_q[0]), 32'(mk(1, 0)));

    // Drop: full FIFO, neuron 2 spikes at 10 and 11
    ev_ready = 1'b0;
    wait_tnow(5);
    log_q.delete();
    spikes = 4'b1111; tick(1); spikes = '0;
    wait_tnow(10);
    spikes = 4'b0100; tick(1);
    spikes = 4'b0100; tick(1);
    spikes = '0;
    check("t5_drop", 32'(drop_count), 1);
    check("t5_level", 32'(fifo_level), 4);
    ev_ready = 1'b1;
    tick(10);
    check("t5_count", log_q.size(), 5);
    if (log_q.size() >= 5) begin
      check("t5_ev0", 32'(log_q[0]), 32'(mk(0, 5)));
      check("t5_ev4", 32'(log_q[4]), 32'(mk(2, 10)));
    end

    // Saturation: hundreds of drops hold at 255
    ev_ready = 1'b0;
    spikes = 4'b1111;
    tick(90);
    check("t6_sat", 32'(drop_count), 255);
    check("t6_full", 32'(fifo_level), 4);

    // Reset mid-operation flushes everything
    rst_n = 1'b0;
    tick(1);
    check("t7_valid", 32'(ev_valid), 0);
    check("t7_level", 32'(fifo_level), 0);
    check("t7_drop", 32'(drop_count), 0);
    rst_n = 1'b1;
    spikes = '0;
    ev_ready = 1'b1;
    log_q.delete();
    tick(10);
    check("t7_no_stale", log_q.size(), 0);
    check("t7_valid_after", 32'(ev_valid), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
